// File: rtl/dircc_types_pkg.sv
// Shared types for the DIRCC RTS scheduler: FSM state encoding and grant record.
package dircc_types_pkg;

  localparam int unsigned PIN_W        = 32;
  localparam int unsigned MAX_DEVICE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_ADDR,
    SCAN_WAIT,
    SCAN_CAP,
    ARB,
    OFFER
  } sched_state_t;

  typedef struct packed {
    logic [MAX_DEVICE_W-1:0] device;
    logic [PIN_W-1:0]        pins;
  } grant_t;

endpackage

// File: rtl/dircc_rr_picker.sv
// Round-robin first-set search: lowest set request at or after ptr, wrapping at N-1.
module dircc_rr_picker #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [N-1:0] rotated;

  // Bit j of rotated is request (ptr + j) mod N.
  assign rotated = N'({req, req} >> ptr);

  always_comb begin
    int unsigned pos;
    pos   = 0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        pos   = 32'(ptr) + j;
        if (pos >= N) pos = pos - N;
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/dircc_rts_scheduler.sv
// Sweeps device contexts through the RTS handler, captures ready pins and
// offers ready devices to the send engine in round-robin order.
module dircc_rts_scheduler
  import dircc_types_pkg::*;
#(
  parameter int unsigned MEM_ADDRESS_WIDTH = 32,
  parameter int unsigned NUM_DEVICES       = 16,
  parameter int unsigned RTS_LATENCY       = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         scan_enable,
  output logic [MEM_ADDRESS_WIDTH-1:0] address,
  input  logic [PIN_W-1:0]             rts_ready,
  output logic                         send_valid,
  output logic [MEM_ADDRESS_WIDTH-1:0] send_device,
  output logic [PIN_W-1:0]             send_pins,
  input  logic                         send_ready,
  output logic                         busy,
  output logic [15:0]                  sweep_count
);

  localparam int unsigned     IDX_W    = $clog2(NUM_DEVICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DEVICES - 1);
  localparam logic [2:0]       LAT_LOAD = 3'(RTS_LATENCY - 1);

  sched_state_t           state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       pick_idx;
  logic [IDX_W-1:0]       grant_idx;
  logic [IDX_W-1:0]       rr_next;
  logic                   pick_found;
  logic [2:0]             lat_cnt;
  logic [NUM_DEVICES-1:0] ready_bits;
  logic [NUM_DEVICES-1:0] cap_bits;
  logic [NUM_DEVICES-1:0] remaining_bits;
  logic [PIN_W-1:0]       pins [NUM_DEVICES];
  grant_t                 grant;
  logic                   last_dev;
  logic                   accept;

  dircc_rr_picker #(
    .N     (NUM_DEVICES),
    .IDX_W (IDX_W)
  ) u_picker (
    .req   (ready_bits),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign last_dev       = (idx == LAST_IDX);
  assign accept         = (state == OFFER) && send_ready;
  assign grant_idx      = grant.device[IDX_W-1:0];
  assign remaining_bits = ready_bits & ~(NUM_DEVICES'(1) << grant_idx);
  assign rr_next        = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  assign busy        = (state != IDLE);
  assign send_valid  = (state == OFFER);
  assign send_device = MEM_ADDRESS_WIDTH'(grant.device);
  assign send_pins   = grant.pins;

  // Ready vector as it will stand after this cycle's capture; the end-of-sweep
  // decision must see the last device's fresh result.
  always_comb begin
    cap_bits      = ready_bits;
    cap_bits[idx] = |rts_ready;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (scan_enable) state_next = SCAN_ADDR;
      SCAN_ADDR: state_next = SCAN_WAIT;
      SCAN_WAIT: if (lat_cnt == '0) state_next = SCAN_CAP;
      SCAN_CAP: begin
        if (!last_dev)         state_next = SCAN_ADDR;
        else if (|cap_bits)    state_next = ARB;
        else if (scan_enable)  state_next = SCAN_ADDR;
        else                   state_next = IDLE;
      end
      ARB: begin
        if (pick_found)        state_next = OFFER;
        else if (scan_enable)  state_next = SCAN_ADDR;
        else                   state_next = IDLE;
      end
      OFFER: begin
        if (accept) begin
          if (|remaining_bits && scan_enable) state_next = ARB;
          else if (scan_enable)               state_next = SCAN_ADDR;
          else                                state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      address     <= '0;
      idx         <= '0;
      rr_ptr      <= '0;
      lat_cnt     <= '0;
      ready_bits  <= '0;
      grant       <= '0;
      sweep_count <= '0;
      for (int unsigned i = 0; i < NUM_DEVICES; i++) pins[i] <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        SCAN_ADDR: begin
          address <= MEM_ADDRESS_WIDTH'(idx);
          lat_cnt <= LAT_LOAD;
        end
        SCAN_WAIT: if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        SCAN_CAP: begin
          ready_bits <= cap_bits;
          pins[idx]  <= rts_ready;
          if (last_dev) begin
            idx         <= '0;
            sweep_count <= sweep_count + 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ARB: begin
          grant.device <= MAX_DEVICE_W'(pick_idx);
          grant.pins   <= pins[pick_idx];
        end
        OFFER: begin
          if (accept) begin
            ready_bits <= remaining_bits;
            rr_ptr     <= rr_next;
          end
        end
        default: ;
      endcase
      if (state != IDLE && state_next == IDLE) begin
        ready_bits <= '0;
        for (int unsigned i = 0; i < NUM_DEVICES; i++) pins[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dircc_rts_scheduler.sv
// Directed bench for dircc_rts_scheduler with a fixed-latency RTS handler model.
module tb_dircc_rts_scheduler;

  logic        clk;
  logic        reset;
  logic        scan_enable;
  logic [31:0] address;
  logic [31:0] rts_ready;
  logic        send_valid;
  logic [31:0] send_device;
  logic [31:0] send_pins;
  logic        send_ready;
  logic        busy;
  logic [15:0] sweep_count;

  logic [31:0] pin_tab [4];
  logic [31:0] addr_d1, addr_d2;

  int n_cmp;
  int n_bad;

  dircc_rts_scheduler #(
    .MEM_ADDRESS_WIDTH (32),
    .NUM_DEVICES       (4),
    .RTS_LATENCY       (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .scan_enable (scan_enable),
    .address     (address),
    .rts_ready   (rts_ready),
    .send_valid  (send_valid),
    .send_device (send_device),
    .send_pins   (send_pins),
    .send_ready  (send_ready),
    .busy        (busy),
    .sweep_count (sweep_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handler model: pins for an address appear two cycles after it is presented.
  always @(posedge clk) begin
    addr_d1 <= address;
    addr_d2 <= addr_d1;
  end
  assign rts_ready = pin_tab[addr_d2[1:0]];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_tab(input logic [31:0] p0, input logic [31:0] p1,
                         input logic [31:0] p2, input logic [31:0] p3);
    pin_tab[0] = p0;
    pin_tab[1] = p1;
    pin_tab[2] = p2;
    pin_tab[3] = p3;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    scan_enable = 1'b0;
    send_ready  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_tab('0, '0, '0, '0);
    reset       = 1'b1;
    scan_enable = 1'b1;
    send_ready  = 1'b0;
    tick();
    tick();
    n_cmp++; if (send_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %0b want 0", send_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_cmp++; if (sweep_count !== 16'd0) begin n_bad++; $display("FAIL reset_sweep got %0d want 0", sweep_count); end
    n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL reset_addr got %0h want 0", address); end
    n_cmp++; if (send_device !== 32'd0) begin n_bad++; $display("FAIL reset_dev got %0h want 0", send_device); end
    n_cmp++; if (send_pins !== 32'd0) begin n_bad++; $display("FAIL reset_pins got %0h want 0", send_pins); end
    reset       = 1'b0;
    scan_enable = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_hold_busy got %0b want 0", busy); end
  endtask

  task automatic test_idle_sweep();
    logic [15:0] exp_sc;
    logic [31:0] exp_addr;
    set_tab('0, '0, '0, '0);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b1;
    for (int t = 1; t <= 65; t++) begin
      tick();
      exp_sc = 16'((t - 1) / 16);
      n_cmp++; if (sweep_count !== exp_sc) begin n_bad++; $display("FAIL idle_sweep_count t=%0d got %0d want %0d", t, sweep_count, exp_sc); end
      n_cmp++; if (send_valid !== 1'b0) begin n_bad++; $display("FAIL idle_sweep_valid t=%0d got %0b want 0", t, send_valid); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL idle_sweep_busy t=%0d got %0b want 1", t, busy); end
      if (t >= 2) begin
        exp_addr = 32'(((t - 2) / 4) % 4);
        n_cmp++; if (address !== exp_addr) begin n_bad++; $display("FAIL idle_sweep_addr t=%0d got %0d want %0d", t, address, exp_addr); end
      end
    end
  endtask

  task automatic test_single_grant();
    int  n_valid;
    logic exp_v;
    set_tab('0, '0, 32'h1, '0);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b1;
    n_valid     = 0;
    for (int t = 1; t <= 72; t++) begin
      tick();
      exp_v = (t % 18 == 0);
      if (send_valid === 1'b1) n_valid++;
      n_cmp++; if (send_valid !== exp_v) begin n_bad++; $display("FAIL single_valid t=%0d got %0b want %0b", t, send_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (send_device !== 32'd2) begin n_bad++; $display("FAIL single_dev t=%0d got %0d want 2", t, send_device); end
        n_cmp++; if (send_pins !== 32'h1) begin n_bad++; $display("FAIL single_pins t=%0d got %0h want 1", t, send_pins); end
      end
    end
    n_cmp++; if (n_valid != 4) begin n_bad++; $display("FAIL single_offer_count got %0d want 4", n_valid); end
    n_cmp++; if (sweep_count !== 16'd4) begin n_bad++; $display("FAIL single_sweep got %0d want 4", sweep_count); end
  endtask

  task automatic test_rr_order();
    int          n_g;
    int          g_tick [8];
    logic [31:0] g_dev  [8];
    logic [31:0] g_pins [8];
    int          e_tick [6];
    logic [31:0] e_dev  [6];
    logic [31:0] e_pins [6];
    e_tick = '{18, 20, 22, 40, 42, 44};
    e_dev  = '{32'd0, 32'd1, 32'd3, 32'd0, 32'd1, 32'd3};
    e_pins = '{32'hA0, 32'hB1, 32'hD3, 32'hA0, 32'hB1, 32'hD3};
    set_tab(32'hA0, 32'hB1, '0, 32'hD3);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b1;
    n_g = 0;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (send_valid === 1'b1 && n_g < 8) begin
        g_tick[n_g] = t;
        g_dev[n_g]  = send_device;
        g_pins[n_g] = send_pins;
        n_g++;
      end
    end
    n_cmp++; if (n_g != 6) begin n_bad++; $display("FAIL rr_grant_count got %0d want 6", n_g); end
    for (int i = 0; i < 6; i++) begin
      if (i < n_g) begin
        n_cmp++; if (g_dev[i] !== e_dev[i]) begin n_bad++; $display("FAIL rr_dev[%0d] got %0d want %0d", i, g_dev[i], e_dev[i]); end
        n_cmp++; if (g_pins[i] !== e_pins[i]) begin n_bad++; $display("FAIL rr_pins[%0d] got %0h want %0h", i, g_pins[i], e_pins[i]); end
        n_cmp++; if (g_tick[i] != e_tick[i]) begin n_bad++; $display("FAIL rr_tick[%0d] got %0d want %0d", i, g_tick[i], e_tick[i]); end
      end
    end
  endtask

  task automatic test_back_pressure();
    set_tab('0, 32'h55, '0, '0);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b0;
    for (int t = 1; t <= 17; t++) tick();
    n_cmp++; if (send_valid !== 1'b0) begin n_bad++; $display("FAIL bp_pre_valid got %0b want 0", send_valid); end
    for (int k = 1; k <= 50; k++) begin
      tick();
      n_cmp++; if (send_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid k=%0d got %0b want 1", k, send_valid); end
      n_cmp++; if (send_device !== 32'd1) begin n_bad++; $display("FAIL bp_hold_dev k=%0d got %0d want 1", k, send_device); end
      n_cmp++; if (send_pins !== 32'h55) begin n_bad++; $display("FAIL bp_hold_pins k=%0d got %0h want 55", k, send_pins); end
    end
    send_ready = 1'b1;
    tick();
    n_cmp++; if (send_valid !== 1'b0) begin n_bad++; $display("FAIL bp_accept_valid got %0b want 0", send_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_accept_busy got %0b want 1", busy); end
    n_cmp++; if (sweep_count !== 16'd1) begin n_bad++; $display("FAIL bp_sweep got %0d want 1", sweep_count); end
  endtask

  task automatic test_scan_enable_drop();
    logic exp_b;
    logic exp_v;
    // All idle: sweep finishes from device 1 through 3, then stops.
    set_tab('0, '0, '0, '0);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b1;
    for (int t = 1; t <= 6; t++) tick();
    n_cmp++; if (address !== 32'd1) begin n_bad++; $display("FAIL drop_addr_dev1 got %0d want 1", address); end
    scan_enable = 1'b0;
    for (int t = 7; t <= 22; t++) begin
      tick();
      exp_b = (t < 17);
      n_cmp++; if (busy !== exp_b) begin n_bad++; $display("FAIL drop_busy t=%0d got %0b want %0b", t, busy, exp_b); end
      if (t == 14) begin
        n_cmp++; if (address !== 32'd3) begin n_bad++; $display("FAIL drop_addr_dev3 got %0d want 3", address); end
      end
    end
    n_cmp++; if (sweep_count !== 16'd1) begin n_bad++; $display("FAIL drop_sweep got %0d want 1", sweep_count); end
    // Devices 1 and 3 ready: only one offer is made before going idle.
    set_tab('0, 32'h7, '0, 32'h5);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b1;
    for (int t = 1; t <= 6; t++) tick();
    scan_enable = 1'b0;
    for (int t = 7; t <= 25; t++) begin
      tick();
      exp_v = (t == 18);
      exp_b = (t <= 18);
      n_cmp++; if (send_valid !== exp_v) begin n_bad++; $display("FAIL drop_offer_valid t=%0d got %0b want %0b", t, send_valid, exp_v); end
      n_cmp++; if (busy !== exp_b) begin n_bad++; $display("FAIL drop_offer_busy t=%0d got %0b want %0b", t, busy, exp_b); end
      if (exp_v) begin
        n_cmp++; if (send_device !== 32'd1) begin n_bad++; $display("FAIL drop_offer_dev got %0d want 1", send_device); end
        n_cmp++; if (send_pins !== 32'h7) begin n_bad++; $display("FAIL drop_offer_pins got %0h want 7", send_pins); end
      end
    end
  endtask

  task automatic test_reset_in_offer();
    set_tab('0, 32'h9, '0, '0);
    do_reset();
    scan_enable = 1'b1;
    send_ready  = 1'b0;
    for (int t = 1; t <= 18; t++) tick();
    n_cmp++; if (send_valid !== 1'b1) begin n_bad++; $display("FAIL rio_pre_valid got %0b want 1", send_valid); end
    reset = 1'b1;
    tick();
    n_cmp++; if (send_valid !== 1'b0) begin n_bad++; $display("FAIL rio_valid got %0b want 0", send_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rio_busy got %0b want 0", busy); end
    n_cmp++; if (sweep_count !== 16'd0) begin n_bad++; $display("FAIL rio_sweep got %0d want 0", sweep_count); end
    n_cmp++; if (send_device !== 32'd0) begin n_bad++; $display("FAIL rio_dev got %0d want 0", send_device); end
    n_cmp++; if (send_pins !== 32'd0) begin n_bad++; $display("FAIL rio_pins got %0h want 0", send_pins); end
    n_cmp++; if (address !== 32'd0) begin n_bad++; $display("FAIL rio_addr got %0d want 0", address); end
    reset      = 1'b0;
    send_ready = 1'b1;
    for (int t = 1; t <= 18; t++) tick();
    n_cmp++; if (send_valid !== 1'b1 || send_device !== 32'd1) begin n_bad++; $display("FAIL rio_recover got valid=%0b dev=%0d want valid=1 dev=1", send_valid, send_device); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    set_tab('0, '0, '0, '0);
    reset       = 1'b1;
    scan_enable = 1'b0;
    send_ready  = 1'b0;
    test_reset();
    test_idle_sweep();
    test_single_grant();
    test_rr_order();
    test_back_pressure();
    test_scan_enable_drop();
    test_reset_in_offer();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
